// File: rtl/float_div_iter.sv
// Iterative restoring floating-point divider: quotient = aIn / bIn.
// Resolves one quotient bit per clock behind a valid/ready handshake.
// Zero-exponent operands are treated as zero (denormals flushed); the result is truncated.
module float_div_iter #(
  parameter int unsigned MANTISSA_SIZE = 23,
  parameter int unsigned EXPONENT_SIZE = 8,
  localparam int unsigned FLOAT_SIZE = 1 + EXPONENT_SIZE + MANTISSA_SIZE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FLOAT_SIZE-1:0] aIn,
  input  logic [FLOAT_SIZE-1:0] bIn,
  input  logic                  inValid,
  output logic                  inReady,
  output logic [FLOAT_SIZE-1:0] quotient,
  output logic                  divByZero,
  output logic                  outValid,
  input  logic                  outReady
);

  localparam int unsigned M    = MANTISSA_SIZE;
  localparam int unsigned E    = EXPONENT_SIZE;
  localparam int unsigned CntW = $clog2(M + 2);
  localparam logic [E+1:0] BiasVec   = (E + 2)'((1 << (E - 1)) - 1);
  localparam logic [E+1:0] MaxExpVec = (E + 2)'((1 << E) - 1);

  typedef enum logic [1:0] {StIdle, StDivide, StNorm, StDone} stateT;

  stateT stateQ, stateD;

  logic [E-1:0]          aExpQ, bExpQ;
  logic                  signQ;
  logic [M:0]            mbQ;
  logic [M+1:0]          remQ, qQ;
  logic [CntW-1:0]       cntQ;
  logic [FLOAT_SIZE-1:0] quotientQ;
  logic                  divByZeroQ;

  // Operand fields taken straight from the inputs on the accept edge.
  logic [E-1:0] aExpIn, bExpIn;
  logic         specialIn;
  logic         accept;

  assign aExpIn    = aIn[M+E-1:M];
  assign bExpIn    = bIn[M+E-1:M];
  assign specialIn = (aExpIn == '0) || (bExpIn == '0);
  assign accept    = (stateQ == StIdle) && inValid;

  // One restoring-division step.
  logic         geMb;
  logic [M+1:0] remSub, remNext;

  always_comb begin
    geMb    = remQ >= {1'b0, mbQ};
    remSub  = geMb ? (remQ - {1'b0, mbQ}) : remQ;
    remNext = remSub << 1;
  end

  // Normalisation, range handling and special-operand results.
  logic [M-1:0]          normMant;
  logic [E+1:0]          expU;
  logic                  expOver, expUnder;
  logic [FLOAT_SIZE-1:0] normResult;
  logic                  normDz;

  always_comb begin
    normMant = qQ[M+1] ? qQ[M:1] : qQ[M-1:0];
    // Two guard bits keep the biased difference signed and overflow-free.
    expU     = {2'b00, aExpQ} - {2'b00, bExpQ} + BiasVec - {{(E + 1){1'b0}}, ~qQ[M+1]};
    expOver  = $signed(expU) >= $signed(MaxExpVec);
    expUnder = expU[E+1] || (expU == '0);
    normDz   = 1'b0;
    if (bExpQ == '0) begin
      normResult = {signQ, {E{1'b1}}, {M{1'b0}}};
      normDz     = 1'b1;
    end else if (aExpQ == '0) begin
      normResult = {signQ, {(E + M){1'b0}}};
    end else if (expOver) begin
      normResult = {signQ, {E{1'b1}}, {M{1'b0}}};
    end else if (expUnder) begin
      normResult = {signQ, {(E + M){1'b0}}};
    end else begin
      normResult = {signQ, expU[E-1:0], normMant};
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stateQ <= StIdle;
    else       stateQ <= stateD;
  end

  // Next-state logic; special operands skip the division and resolve in StNorm.
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      StIdle:   if (inValid) stateD = specialIn ? StNorm : StDivide;
      StDivide: if (cntQ == CntW'(M + 1)) stateD = StNorm;
      StNorm:   stateD = StDone;
      StDone:   if (outReady) stateD = StIdle;
      default:  stateD = StIdle;
    endcase
  end

  // Datapath registers: operand capture, iteration, result latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aExpQ      <= '0;
      bExpQ      <= '0;
      signQ      <= 1'b0;
      mbQ        <= '0;
      remQ       <= '0;
      qQ         <= '0;
      cntQ       <= '0;
      quotientQ  <= '0;
      divByZeroQ <= 1'b0;
    end else begin
      if (accept) begin
        aExpQ <= aExpIn;
        bExpQ <= bExpIn;
        signQ <= aIn[FLOAT_SIZE-1] ^ bIn[FLOAT_SIZE-1];
        mbQ   <= {1'b1, bIn[M-1:0]};
        remQ  <= {2'b01, aIn[M-1:0]};
        qQ    <= '0;
        cntQ  <= '0;
      end
      if (stateQ == StDivide) begin
        remQ <= remNext;
        qQ   <= {qQ[M:0], geMb};
        cntQ <= cntQ + 1'b1;
      end
      if (stateQ == StNorm) begin
        quotientQ  <= normResult;
        divByZeroQ <= normDz;
      end
    end
  end

  assign inReady   = (stateQ == StIdle);
  assign outValid  = (stateQ == StDone);
  assign quotient  = quotientQ;
  assign divByZero = divByZeroQ;

endmodule

// File: tb/tb_float_div_iter.sv
// Directed self-checking bench for float_div_iter with default parameters.
module tb_float_div_iter;

  logic        clk;
  logic        reset;
  logic [31:0] aIn, bIn;
  logic        inValid;
  logic        inReady;
  logic [31:0] quotient;
  logic        divByZero;
  logic        outValid;
  logic        outReady;

  int nChecks = 0;
  int nFails  = 0;
  int lat;
  int seen;

  float_div_iter dut (
    .clk      (clk),
    .reset    (reset),
    .aIn      (aIn),
    .bIn      (bIn),
    .inValid  (inValid),
    .inReady  (inReady),
    .quotient (quotient),
    .divByZero(divByZero),
    .outValid (outValid),
    .outReady (outReady)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present operands at a falling edge; return 1 ns after the accept edge.
  task automatic startOp(input string tag, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    chk({tag, " inReady before accept"}, {31'b0, inReady}, 32'd1);
    aIn     = a;
    bIn     = b;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    aIn     = $urandom;
    bIn     = $urandom;
  endtask

  // Count edges from the accept edge until outValid rises (bounded).
  task automatic waitResult(input string tag, input int expLat);
    lat = 1;
    @(posedge clk);
    #1;
    while (outValid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(expLat));
  endtask

  task automatic finishOp(input string tag, input logic [31:0] expQ, input logic expDz,
                          input int expLat);
    waitResult(tag, expLat);
    chk({tag, " quotient"}, quotient, expQ);
    chk({tag, " divByZero"}, {31'b0, divByZero}, {31'b0, expDz});
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    chk({tag, " outValid after take"}, {31'b0, outValid}, 32'd0);
    chk({tag, " inReady after take"}, {31'b0, inReady}, 32'd1);
  endtask

  initial begin
    reset    = 1'b1;
    aIn      = '0;
    bIn      = '0;
    inValid  = 1'b0;
    outReady = 1'b0;
    #1;
    chk("reset outValid", {31'b0, outValid}, 32'd0);
    chk("reset inReady", {31'b0, inReady}, 32'd1);
    chk("reset quotient", quotient, 32'h0);
    chk("reset divByZero", {31'b0, divByZero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    startOp("6/2", 32'h40C00000, 32'h40000000);
    finishOp("6/2", 32'h40400000, 1'b0, 26);

    startOp("1/3", 32'h3F800000, 32'h40400000);
    finishOp("1/3", 32'h3EAAAAAA, 1'b0, 26);

    startOp("-7.5/0.5", 32'hC0F00000, 32'h3F000000);
    finishOp("-7.5/0.5", 32'hC1700000, 1'b0, 26);

    startOp("overflow", 32'h7F000000, 32'h00800000);
    finishOp("overflow", 32'h7F800000, 1'b0, 26);

    startOp("underflow", 32'h00800000, 32'h7F000000);
    finishOp("underflow", 32'h00000000, 1'b0, 26);

    startOp("-0/5", 32'h80000000, 32'h40A00000);
    finishOp("-0/5", 32'h80000000, 1'b0, 1);

    // Backpressure: hold the result while inValid pulses with new operands.
    startOp("bp 6/2", 32'h40C00000, 32'h40000000);
    waitResult("bp 6/2", 26);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      inValid = 1'b1;
      aIn     = $urandom;
      bIn     = $urandom;
      @(posedge clk);
      #1;
      chk("bp quotient held", quotient, 32'h40400000);
      chk("bp inReady low", {31'b0, inReady}, 32'd0);
      chk("bp outValid held", {31'b0, outValid}, 32'd1);
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    chk("bp outValid drop", {31'b0, outValid}, 32'd0);
    chk("bp inReady back", {31'b0, inReady}, 32'd1);
    // Back-to-back accept on the very next edge.
    aIn     = 32'h3F800000;
    bIn     = 32'h40400000;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    chk("b2b accepted", {31'b0, inReady}, 32'd0);
    finishOp("b2b 1/3", 32'h3EAAAAAA, 1'b0, 26);

    startOp("1/0", 32'h3F800000, 32'h00000000);
    finishOp("1/0", 32'h7F800000, 1'b1, 1);

    // Abort mid-division with an asynchronous reset.
    startOp("abort 6/2", 32'h40C00000, 32'h40000000);
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort outValid", {31'b0, outValid}, 32'd0);
    chk("abort inReady", {31'b0, inReady}, 32'd1);
    chk("abort quotient", quotient, 32'h0);
    chk("abort divByZero", {31'b0, divByZero}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen  = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (outValid === 1'b1) seen++;
    end
    chk("abort no outValid", 32'(seen), 32'd0);

    startOp("post-abort 1/3", 32'h3F800000, 32'h40400000);
    finishOp("post-abort 1/3", 32'h3EAAAAAA, 1'b0, 26);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/float_div_iter.md
Name: float_div_iter

Overview:
Iterative floating-point divider computing quotient = aIn / bIn in the team's parameterised float format (sign | exponent | mantissa, hidden-one, biased exponent). It is the inverse-operation companion to the pipelined float adder/multiplier datapath. It resolves one quotient bit per clock using restoring division, so it trades throughput for area. It sits behind a valid/ready handshake so the surrounding pipeline can stall on it.

Parameters:
MANTISSA_SIZE, 23, stored mantissa bits M.
EXPONENT_SIZE, 8, exponent bits E; bias = 2^(E-1)-1.
FLOAT_SIZE, 1+E+M, derived localparam; not overridable.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-high reset.
aIn  in  FLOAT_SIZE  dividend; sampled on accept.
bIn  in  FLOAT_SIZE  divisor; sampled on accept.
inValid  in  1  operands present.
inReady  out  1  block can accept; high only in IDLE.
quotient  out  FLOAT_SIZE  result; stable while outValid=1.
divByZero  out  1  set with the result when the divisor is zero.
outValid  out  1  result available.
outReady  in  1  consumer takes result.

Behaviour:
- Reset (async assert, any state) -> IDLE; outValid=0, quotient=0, divByZero=0, inReady=1, counter=0, internal registers=0.
- States: IDLE, DIVIDE, NORM, DONE.
- IDLE: inReady=1. The accept edge is inValid=1 at a rising edge. On it, register the operands and the sign (sa XOR sb).
  - Special operand (exponent 0 on either side) -> DONE on the next edge.
  - Otherwise -> DIVIDE.
- Operands with exponent 0 are treated as zero; denormals are flushed. Exponent all-ones inputs are not special-cased; they are treated as ordinary numbers.
- Special results:
  - bExp=0: quotient = {sign, all-ones exponent, 0}, divByZero=1. This includes 0/0.
  - aExp=0, bExp!=0: quotient = {sign, 0, 0}.
- DIVIDE: mantissas ma={1,aMant} and mb={1,bMant}, each M+1 bits. The remainder register is M+2 bits wide and is initialised to ma.
  - Each cycle: if rem >= mb then qbit=1 and rem = rem - mb, else qbit=0. Then rem <<= 1 and q = {q, qbit}.
  - Run exactly M+2 iterations, tracked by a counter 0..M+1, then -> NORM.
  - The q register is M+2 bits and is cleared on accept.
- NORM (one cycle):
  - If q[M+1]=1: mant=q[M:1], e=aExp-bExp+bias.
  - Else: mant=q[M-1:0], e=aExp-bExp+bias-1.
  - e is computed signed with E+2 bits.
  - No rounding; the quotient is truncated.
  - e >= 2^E-1: quotient = {sign, all-ones, 0} (overflow to inf), divByZero=0.
  - e <= 0: quotient = {sign, 0, 0} (underflow to zero).
  - Otherwise: quotient = {sign, e[E-1:0], mant}.
  - -> DONE.
- DONE: outValid=1. quotient and divByZero are held unchanged while outReady=0. On an edge with outReady=1 -> IDLE and outValid=0.
- inReady=0 in DIVIDE, NORM and DONE. No new operand is accepted in the same cycle a result is consumed; the earliest next accept is the edge after the return to IDLE.
- Latency, counted from the accept edge to the edge at which outValid rises:
  - Normal operands: M+3 edges (26 for default parameters).
  - Special operands: 1 edge.
- inValid deasserted while not in IDLE is ignored. Changes on aIn/bIn after accept do not affect the result.
- Reset asserted mid-DIVIDE or in DONE discards the operation; no outValid pulse follows.

Test Plan:
- 0x40C00000 / 0x40000000 (6.0/2.0) -> quotient 0x40400000, divByZero=0, outValid rises 26 edges after accept.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAA (truncated); 0xC0F00000 / 0x3F000000 (-7.5/0.5) -> 0xC1700000.
- 0x3F800000 / 0x00000000 -> 0x7F800000, divByZero=1, 1-edge latency; 0x80000000 / 0x40A00000 -> 0x80000000, divByZero=0.
- Range checks:
  - 0x7F000000 / 0x00800000 -> 0x7F800000 (overflow).
  - 0x00800000 / 0x7F000000 -> 0x00000000 (underflow).
- Backpressure:
  - Hold outReady=0 for 5 cycles in DONE: quotient stable, inReady=0, inValid pulses ignored.
  - Release outReady: outValid drops next edge; inReady=1; back-to-back accept works on the following edge.
- Assert reset at iteration 10 of 6.0/2.0: all outputs 0 and inReady=1 immediately (async). Apply a new 1/3 after release -> 0x3EAAAAAA, unaffected by the aborted operation.
